pp_freq_sequencer: RTL and testbench

//  Front-panel controller for the push-pull / Tesla burst driver. Debounces the

---
 rtl/pp_freq_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_pp_freq_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pp_freq_sequencer.sv
// Front-panel frequency sequencer: debounced UP/DOWN buttons step the drive frequency,
// a shared restoring divider derives the period timing, and the set is handed over on period_start.
module pp_freq_sequencer #(
    parameter int unsigned BASE_TICKS   = 25000000,
    parameter int unsigned F_MIN        = 1000,
    parameter int unsigned F_MAX        = 32767,
    parameter int unsigned F_DEFAULT    = 15110,
    parameter int unsigned F_STEP       = 511,
    parameter int unsigned BURST_MULT   = 128,
    parameter int unsigned PEAKS        = 50,
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned REPEAT_CYC   = 25000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        btn_down_n_i,
    input  logic        btn_up_n_i,
    input  logic        period_start_i,
    input  logic        cfg_ack_i,
    output logic        cfg_valid_o,
    output logic [15:0] cfg_freq_o,
    output logic [25:0] cfg_p_end_o,
    output logic [25:0] cfg_q1_end_o,
    output logic [25:0] cfg_h_end_o,
    output logic [25:0] cfg_q3_end_o,
    output logic [25:0] cfg_burst_st_o,
    output logic [7:0]  cfg_burst_dv_o,
    output logic        step_led_o,
    output logic        busy_o
);
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int RP_W = $clog2(REPEAT_CYC + 1);

    typedef enum logic [2:0] {IDLE, CALC_P, CALC_T, DERIVE, WAIT_PS, OFFER} state_e;
    state_e state_q, state_d;

    // Bit 0 is UP, bit 1 is DOWN; both held as active-high "pressed".
    logic [1:0]      sync1_q, sync2_q, stable_q, stablePrev_q;
    logic [DB_W-1:0] dbCnt_q [2];
    logic [RP_W-1:0] repCnt_q;
    logic [1:0]      pressEdge;
    logic            singleHeld, repeatFire, stepUp, stepDn, stepAny, fChange;

    logic [15:0] f_q, fCalc_q, fStep_d, fUp, fDn;
    logic [16:0] fUpSum;
    logic        pending_q, stepLed_q;

    logic [21:0] rem_q, divisor, remNext;
    logic [25:0] quo_q, quo_d, dvd_q, pEnd_q, bst_q, q1, h, w;
    logic [22:0] trial;
    logic [4:0]  divCnt_q;
    logic [7:0]  dv_q;
    logic        qBit, divLast;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q      <= 2'b00;
            sync2_q      <= 2'b00;
            stable_q     <= 2'b00;
            stablePrev_q <= 2'b00;
            dbCnt_q[0]   <= '0;
            dbCnt_q[1]   <= '0;
        end else begin
            sync1_q      <= {~btn_down_n_i, ~btn_up_n_i};
            sync2_q      <= sync1_q;
            stablePrev_q <= stable_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    dbCnt_q[i] <= '0;
                end else if (dbCnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    stable_q[i] <= sync2_q[i];
                    dbCnt_q[i]  <= '0;
                end else begin
                    dbCnt_q[i] <= dbCnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign pressEdge  = stable_q & ~stablePrev_q;
    assign singleHeld = stable_q[0] ^ stable_q[1];
    assign repeatFire = singleHeld && (pressEdge == 2'b00) && (repCnt_q == RP_W'(REPEAT_CYC - 1));
    assign stepUp     = singleHeld && stable_q[0] && (pressEdge[0] || repeatFire);
    assign stepDn     = singleHeld && stable_q[1] && (pressEdge[1] || repeatFire);
    assign stepAny    = stepUp || stepDn;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            repCnt_q <= '0;
        end else if (!singleHeld || (pressEdge != 2'b00) || repeatFire) begin
            repCnt_q <= '0;
        end else begin
            repCnt_q <= repCnt_q + 1'b1;
        end
    end

    assign fUpSum = {1'b0, f_q} + 17'(F_STEP);
    assign fUp    = (fUpSum > 17'(F_MAX)) ? 16'(F_MAX) : fUpSum[15:0];
    assign fDn    = (f_q < 16'(F_MIN + F_STEP)) ? 16'(F_MIN) : f_q - 16'(F_STEP);

    always_comb begin
        fStep_d = f_q;
        if (stepUp) begin
            fStep_d = fUp;
        end else if (stepDn) begin
            fStep_d = fDn;
        end
    end

    assign fChange = stepAny && (fStep_d != f_q);

    // fCalc_q freezes the code being computed so later steps only re-arm pending.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            f_q       <= 16'(F_DEFAULT);
            fCalc_q   <= 16'(F_DEFAULT);
            pending_q <= 1'b0;
            stepLed_q <= 1'b0;
        end else begin
            f_q <= fStep_d;
            if (stepAny) begin
                stepLed_q <= ~stepLed_q;
            end
            if (state_q == IDLE && pending_q) begin
                fCalc_q <= f_q;
            end
            if (fChange) begin
                pending_q <= 1'b1;
            end else if (state_q == IDLE) begin
                pending_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CALC_P;
        end else begin
            state_q <= state_d;
        end
    end

    assign divLast = (divCnt_q == 5'd25);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pending_q)      state_d = CALC_P;
            CALC_P:  if (divLast)        state_d = CALC_T;
            CALC_T:  if (divLast)        state_d = DERIVE;
            DERIVE:                      state_d = WAIT_PS;
            WAIT_PS: if (period_start_i) state_d = OFFER;
            OFFER:   if (cfg_ack_i)      state_d = IDLE;
            default:                     state_d = CALC_P;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != IDLE);
        cfg_valid_o = (state_q == OFFER);
    end

    assign divisor = (state_q == CALC_T) ? 22'(32'(fCalc_q) * BURST_MULT) : {6'b0, fCalc_q};
    assign trial   = {rem_q, dvd_q[25]};
    assign qBit    = (trial >= {1'b0, divisor});
    assign remNext = qBit ? 22'(trial - {1'b0, divisor}) : trial[21:0];
    assign quo_d   = {quo_q[24:0], qBit};

    assign q1 = pEnd_q >> 2;
    assign h  = pEnd_q >> 1;
    assign w  = 26'(32'(dv_q) * 32'(PEAKS * 2));

    // Each division re-arms its own registers on its last bit so CALC_T starts clean.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q          <= '0;
            quo_q          <= '0;
            dvd_q          <= 26'(BASE_TICKS);
            divCnt_q       <= '0;
            pEnd_q         <= '0;
            dv_q           <= '0;
            bst_q          <= '0;
            cfg_freq_o     <= '0;
            cfg_p_end_o    <= '0;
            cfg_q1_end_o   <= '0;
            cfg_h_end_o    <= '0;
            cfg_q3_end_o   <= '0;
            cfg_burst_st_o <= '0;
            cfg_burst_dv_o <= '0;
        end else begin
            if (state_q == CALC_P || state_q == CALC_T) begin
                if (divLast) begin
                    rem_q    <= '0;
                    quo_q    <= '0;
                    dvd_q    <= 26'(BASE_TICKS);
                    divCnt_q <= '0;
                    if (state_q == CALC_P) begin
                        pEnd_q <= quo_d;
                    end else begin
                        dv_q <= (quo_d > 26'd255) ? 8'hFF : quo_d[7:0];
                    end
                end else begin
                    rem_q    <= remNext;
                    quo_q    <= quo_d;
                    dvd_q    <= {dvd_q[24:0], 1'b0};
                    divCnt_q <= divCnt_q + 1'b1;
                end
            end
            if (state_q == DERIVE) begin
                bst_q <= (w > q1) ? 26'd0 : q1 - w;
            end
            if (state_q == WAIT_PS && period_start_i) begin
                cfg_freq_o     <= fCalc_q;
                cfg_p_end_o    <= pEnd_q;
                cfg_q1_end_o   <= q1;
                cfg_h_end_o    <= h;
                cfg_q3_end_o   <= q1 + h;
                cfg_burst_st_o <= bst_q;
                cfg_burst_dv_o <= dv_q;
            end
        end
    end

    assign step_led_o = stepLed_q;
endmodule

// File: tb/tb_pp_freq_sequencer.sv
// Directed bench for pp_freq_sequencer: table of button presses with hand-computed timing sets,
// plus hand-written sequences for reset, handshake stall, pending steps, bounce and mid-division reset.
module tb_pp_freq_sequencer;
    localparam int DEB         = 16;
    localparam int REP         = 100;
    localparam int PEAKS_TB    = 2;
    localparam int PS_INTERVAL = 40;

    logic        clk = 1'b0;
    logic        rst, btnDownN, btnUpN, periodStart, cfgAck;
    logic        cfgValid, stepLed, busy;
    logic [15:0] cfgFreq;
    logic [25:0] cfgPEnd, cfgQ1End, cfgHEnd, cfgQ3End, cfgBurstSt;
    logic [7:0]  cfgBurstDv;

    always #5 clk = ~clk;

    pp_freq_sequencer #(
        .DEBOUNCE_CYC(DEB),
        .REPEAT_CYC  (REP),
        .PEAKS       (PEAKS_TB)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .btn_down_n_i  (btnDownN),
        .btn_up_n_i    (btnUpN),
        .period_start_i(periodStart),
        .cfg_ack_i     (cfgAck),
        .cfg_valid_o   (cfgValid),
        .cfg_freq_o    (cfgFreq),
        .cfg_p_end_o   (cfgPEnd),
        .cfg_q1_end_o  (cfgQ1End),
        .cfg_h_end_o   (cfgHEnd),
        .cfg_q3_end_o  (cfgQ3End),
        .cfg_burst_st_o(cfgBurstSt),
        .cfg_burst_dv_o(cfgBurstDv),
        .step_led_o    (stepLed),
        .busy_o        (busy)
    );

    typedef struct {
        logic        up;
        logic        dn;
        int          hold;
        logic [15:0] f;
        logic [25:0] p;
        logic [25:0] q1;
        logic [25:0] h;
        logic [25:0] q3;
        logic [7:0]  dv;
        logic [25:0] bst;
        int          toggles;
        int          offers;
    } vec_t;

    vec_t vecs[4];
    vec_t defaultSet, set2022, set2533;

    int   checkCount = 0;
    int   failCount  = 0;
    int   psCnt      = 0;
    int   ledToggles = 0;
    int   offerCount = 0;
    int   busyCycles = 0;
    logic ledPrev    = 1'b0;
    logic psEnable   = 1'b0;
    logic autoAck    = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t snapOut();
        vec_t s;
        s = '{up: 1'b0, dn: 1'b0, hold: 0, f: cfgFreq, p: cfgPEnd, q1: cfgQ1End, h: cfgHEnd,
              q3: cfgQ3End, dv: cfgBurstDv, bst: cfgBurstSt, toggles: 0, offers: 0};
        return s;
    endfunction

    function automatic logic sameSet(input vec_t a, input vec_t b);
        return (a.f === b.f) && (a.p === b.p) && (a.q1 === b.q1) && (a.h === b.h) &&
               (a.q3 === b.q3) && (a.dv === b.dv) && (a.bst === b.bst);
    endfunction

    task automatic checkSet(input string tag, input vec_t exp);
        vec_t act;
        act = snapOut();
        checkOutput({tag, ".freq"},     32'(act.f),   32'(exp.f));
        checkOutput({tag, ".p_end"},    32'(act.p),   32'(exp.p));
        checkOutput({tag, ".q1_end"},   32'(act.q1),  32'(exp.q1));
        checkOutput({tag, ".h_end"},    32'(act.h),   32'(exp.h));
        checkOutput({tag, ".q3_end"},   32'(act.q3),  32'(exp.q3));
        checkOutput({tag, ".burst_dv"}, 32'(act.dv),  32'(exp.dv));
        checkOutput({tag, ".burst_st"}, 32'(act.bst), 32'(exp.bst));
    endtask

    // One clock: observe at the falling edge, then drive the next inputs.
    task automatic tick();
        @(negedge clk);
        if (stepLed !== ledPrev) ledToggles++;
        ledPrev = stepLed;
        if (busy === 1'b1) busyCycles++;
        if (autoAck && cfgValid === 1'b1) begin
            offerCount++;
            cfgAck = 1'b1;
        end else begin
            cfgAck = 1'b0;
        end
        psCnt++;
        periodStart = psEnable && (psCnt % PS_INTERVAL == 0);
    endtask

    task automatic applyStimulus(input logic up, input logic dn, input int hold);
        btnUpN   = ~up;
        btnDownN = ~dn;
        repeat (hold) tick();
        btnUpN   = 1'b1;
        btnDownN = 1'b1;
    endtask

    task automatic waitQuiet(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 60 && n < 20000) begin
            tick();
            if (busy === 1'b0 && cfgValid === 1'b0) quiet++;
            else quiet = 0;
            n++;
        end
        checkOutput({tag, ".settle"}, 32'(quiet >= 60), 32'd1);
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        while (cfgValid !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        checkOutput({tag, ".valid_seen"}, 32'(cfgValid), 32'd1);
    endtask

    initial begin
        vec_t snap0;
        logic stable;
        int   n;

        defaultSet = '{1'b0, 1'b0, 0, 16'd15110, 26'd1654, 26'd413, 26'd827, 26'd1240, 8'd12, 26'd365, 0, 0};
        set2022    = '{1'b0, 1'b0, 0, 16'd2022, 26'd12363, 26'd3090, 26'd6181, 26'd9271, 8'd96, 26'd2706, 0, 0};
        set2533    = '{1'b0, 1'b0, 0, 16'd2533, 26'd9869, 26'd2467, 26'd4934, 26'd7401, 8'd77, 26'd2159, 0, 0};
        vecs[0] = '{1'b1, 1'b0, 24, 16'd15621, 26'd1600, 26'd400, 26'd800, 26'd1200, 8'd12, 26'd352, 1, 1};
        vecs[1] = '{1'b0, 1'b1, DEB + 3 + 31 * REP + REP / 2, 16'd1000, 26'd25000, 26'd6250, 26'd12500,
                    26'd18750, 8'd195, 26'd5470, 32, -1};
        vecs[2] = '{1'b1, 1'b0, 24, 16'd1511, 26'd16545, 26'd4136, 26'd8272, 26'd12408, 8'd129, 26'd3620, 1, 1};
        vecs[3] = '{1'b1, 1'b1, 200, 16'd1511, 26'd16545, 26'd4136, 26'd8272, 26'd12408, 8'd129, 26'd3620, 0, 0};

        rst = 1'b1; btnUpN = 1'b1; btnDownN = 1'b1; periodStart = 1'b0; cfgAck = 1'b0;
        repeat (3) tick();
        checkOutput("reset.cfg_valid", 32'(cfgValid), 32'd0);
        checkOutput("reset.cfg_freq",  32'(cfgFreq),  32'd0);
        checkOutput("reset.p_end",     32'(cfgPEnd),  32'd0);
        checkOutput("reset.burst_dv",  32'(cfgBurstDv), 32'd0);
        checkOutput("reset.step_led",  32'(stepLed),  32'd0);
        checkOutput("reset.busy",      32'(busy),     32'd1);
        rst = 1'b0;

        // Default set: held in WAIT_PS until the driver's period_start at cycle 100.
        for (int c = 1; c < 100; c++) begin
            tick();
            if (c == 20) periodStart = 1'b1;
            if (c == 50) cfgAck = 1'b1;
        end
        checkOutput("t1.valid_before_ps", 32'(cfgValid), 32'd0);
        checkOutput("t1.busy_before_ps",  32'(busy),     32'd1);
        periodStart = 1'b1;
        tick();
        checkOutput("t1.valid_after_ps", 32'(cfgValid), 32'd1);
        checkSet("t1", defaultSet);
        snap0  = snapOut();
        stable = 1'b1;
        repeat (500) begin
            tick();
            if (cfgValid !== 1'b1 || !sameSet(snapOut(), snap0)) stable = 1'b0;
        end
        checkOutput("t1.stall_stable", 32'(stable), 32'd1);
        cfgAck = 1'b1;
        tick();
        checkOutput("t1.valid_after_ack", 32'(cfgValid), 32'd0);
        checkOutput("t1.busy_after_ack",  32'(busy),     32'd0);

        psEnable = 1'b1;
        autoAck  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ledToggles = 0;
            offerCount = 0;
            applyStimulus(vecs[i].up, vecs[i].dn, vecs[i].hold);
            waitQuiet($sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d.led_toggles", i), 32'(ledToggles), 32'(vecs[i].toggles));
            if (vecs[i].offers >= 0)
                checkOutput($sformatf("vec%0d.offers", i), 32'(offerCount), 32'(vecs[i].offers));
            checkSet($sformatf("vec%0d", i), vecs[i]);
        end

        // Bouncing UP contacts never stay low long enough to register.
        ledToggles = 0;
        busyCycles = 0;
        repeat (20) begin
            btnUpN = 1'b0;
            repeat (10) tick();
            btnUpN = 1'b1;
            repeat (10) tick();
        end
        waitQuiet("t4");
        checkOutput("t4.led_toggles", 32'(ledToggles), 32'd0);
        checkOutput("t4.busy_cycles", 32'(busyCycles), 32'd0);
        checkOutput("t4.freq_kept",   32'(cfgFreq),    32'd1511);

        // A step while an offer is stalled must queue a second offer with the newest code.
        autoAck = 1'b0;
        applyStimulus(1'b1, 1'b0, 24);
        waitValid("t5a");
        checkSet("t5a", set2022);
        snap0 = snapOut();
        applyStimulus(1'b1, 1'b0, 24);
        repeat (100) tick();
        checkOutput("t5.valid_held", 32'(cfgValid), 32'd1);
        checkOutput("t5.set_held",   32'(sameSet(snapOut(), snap0)), 32'd1);
        cfgAck = 1'b1;
        tick();
        checkOutput("t5.valid_drop", 32'(cfgValid), 32'd0);
        waitValid("t5b");
        checkSet("t5b", set2533);
        cfgAck = 1'b1;
        tick();
        autoAck = 1'b1;
        waitQuiet("t5");

        // Reset 10 cycles into CALC_T aborts the computation and restores reset outputs.
        btnUpN = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checkOutput("t6.calc_started", 32'(busy), 32'd1);
        repeat (36) tick();
        rst = 1'b1;
        #1;
        checkOutput("t6.rst_valid",    32'(cfgValid), 32'd0);
        checkOutput("t6.rst_freq",     32'(cfgFreq),  32'd0);
        checkOutput("t6.rst_p_end",    32'(cfgPEnd),  32'd0);
        checkOutput("t6.rst_burst_st", 32'(cfgBurstSt), 32'd0);
        checkOutput("t6.rst_step_led", 32'(stepLed),  32'd0);
        btnUpN  = 1'b1;
        autoAck = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        waitValid("t6");
        checkSet("t6", defaultSet);
        cfgAck = 1'b1;
        tick();
        checkOutput("t6.valid_drop", 32'(cfgValid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
